// File: rtl/hartslag_pkg.sv
// Shared types and defaults for the heartbeat ("hartslag") measurement path.
package hartslag_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam int unsigned TICK_DIV_DEFAULT = 65536;
    localparam int unsigned CNT_W_DEFAULT    = 8;

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchroniser for an asynchronous level input plus rising-edge strobe.
module pulse_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise_c
);

    logic sync1;
    logic sync2;
    logic sync3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise_c = sync2 & ~sync3;

endmodule

// File: rtl/beat_interval_ctrl.sv
// Beat-to-beat interval timer with artefact rejection, loss detection and a
// moving average over 2^AVG_LOG2 accepted intervals.
module beat_interval_ctrl
    import hartslag_pkg::*;
#(
    parameter int unsigned TICK_DIV  = TICK_DIV_DEFAULT,
    parameter int unsigned CNT_W     = CNT_W_DEFAULT,
    parameter int unsigned MIN_TICKS = 20,
    parameter int unsigned MAX_TICKS = 250,
    parameter int unsigned AVG_LOG2  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] avg_interval,
    output logic             avg_valid,
    output logic             locked,
    output logic             artefact,
    output logic             signal_lost
);

    localparam int unsigned PRE_W  = $clog2(TICK_DIV);
    localparam int unsigned DEPTH  = 1 << AVG_LOG2;
    localparam int unsigned SUM_W  = CNT_W + AVG_LOG2;
    localparam int unsigned FILL_W = $clog2(DEPTH + 1);

    state_t             state;
    state_t             state_nxt;
    logic               rise_c;
    logic               tick_c;
    logic               timeout_c;
    logic               accept_c;
    logic               reject_c;
    logic               clear_c;
    logic [PRE_W-1:0]   presc;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   win [DEPTH];
    logic [SUM_W-1:0]   sum;
    logic [FILL_W-1:0]  fill;
    logic               publish_pend;

    pulse_sync_edge u_sync (
        .clk    (clk),
        .reset  (reset),
        .din    (pulse_in),
        .rise_c (rise_c)
    );

    assign tick_c = (state == MEASURE) && (presc == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = ARM;
                ARM:     if (rise_c) state_nxt = MEASURE;
                MEASURE: if (timeout_c) state_nxt = ARM;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Timeout is evaluated before the edge so a coincident edge is dropped.
    always_comb begin
        timeout_c = 1'b0;
        accept_c  = 1'b0;
        reject_c  = 1'b0;
        clear_c   = ~enable;
        if (enable && state == MEASURE) begin
            timeout_c = tick_c && (cnt == CNT_W'(MAX_TICKS - 1));
            if (rise_c && !timeout_c) begin
                if (cnt < CNT_W'(MIN_TICKS)) reject_c = 1'b1;
                else                         accept_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                      presc <= '0;
        else if (state != MEASURE || accept_c || tick_c) presc <= '0;
        else                                            presc <= presc + PRE_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (state != MEASURE || accept_c)
            cnt <= '0;
        else if (tick_c && cnt != CNT_W'(MAX_TICKS))
            cnt <= cnt + CNT_W'(1);
    end

    // Averaging window: oldest entry leaves the running sum as the new one enters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) win[i] <= '0;
            sum  <= '0;
            fill <= '0;
        end else if (clear_c || timeout_c) begin
            for (int unsigned i = 0; i < DEPTH; i++) win[i] <= '0;
            sum  <= '0;
            fill <= '0;
        end else if (accept_c) begin
            win[0] <= cnt;
            for (int unsigned i = 1; i < DEPTH; i++) win[i] <= win[i-1];
            sum <= sum + SUM_W'(cnt) - SUM_W'(win[DEPTH-1]);
            if (fill != FILL_W'(DEPTH)) fill <= fill + FILL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) publish_pend <= 1'b0;
        else       publish_pend <= accept_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avg_interval <= '0;
            avg_valid    <= 1'b0;
            locked       <= 1'b0;
            artefact     <= 1'b0;
            signal_lost  <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            artefact  <= reject_c;
            if (clear_c) begin
                locked      <= 1'b0;
                signal_lost <= 1'b0;
            end else if (timeout_c) begin
                locked      <= 1'b0;
                signal_lost <= 1'b1;
            end else begin
                if (accept_c) signal_lost <= 1'b0;
                if (publish_pend && fill == FILL_W'(DEPTH)) begin
                    avg_interval <= CNT_W'(sum >> AVG_LOG2);
                    avg_valid    <= 1'b1;
                    locked       <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_beat_interval_ctrl.sv
// Randomised scoreboard bench for beat_interval_ctrl against a timestamp-based
// reference model (intervals from edge cycle differences, averages from a queue).
module tb_beat_interval_ctrl;
    import hartslag_pkg::*;

    localparam int TD    = 4;
    localparam int MINT  = 3;
    localparam int MAXT  = 20;
    localparam int LOG2  = 2;
    localparam int DEPTH = 1 << LOG2;

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       pulse_in = 1'b0;
    logic [7:0] avg_interval;
    logic       avg_valid;
    logic       locked;
    logic       artefact;
    logic       signal_lost;

    int     cyc = 0;
    int     n_chk = 0;
    int     n_pass = 0;
    bit     edge_due [int];
    exp_t   vq [$];
    int     aq [$];
    int     vr = 0;
    int     ar = 0;

    state_t m_state = IDLE;
    int     m_avg = 0;
    bit     m_locked = 1'b0;
    bit     m_lost = 1'b0;

    beat_interval_ctrl #(
        .TICK_DIV  (TD),
        .CNT_W     (8),
        .MIN_TICKS (MINT),
        .MAX_TICKS (MAXT),
        .AVG_LOG2  (LOG2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .pulse_in     (pulse_in),
        .avg_interval (avg_interval),
        .avg_valid    (avg_valid),
        .locked       (locked),
        .artefact     (artefact),
        .signal_lost  (signal_lost)
    );

    always #5 clk = ~clk;

    // Reference model: edges land 3 clk after the rise the stimulus records.
    initial begin
        int  win [$];
        int  t0;
        int  d;
        int  ticks;
        int  s;
        bit  pend;
        bit  e;
        t0   = 0;
        pend = 1'b0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_state  = IDLE;
                m_locked = 1'b0;
                m_lost   = 1'b0;
                m_avg    = 0;
                win.delete();
                pend     = 1'b0;
            end else begin
                cyc++;
                e = edge_due.exists(cyc);
                if (!enable) begin
                    m_state  = IDLE;
                    m_locked = 1'b0;
                    m_lost   = 1'b0;
                    win.delete();
                    pend     = 1'b0;
                end else begin
                    if (pend && win.size() == DEPTH) begin
                        s = 0;
                        foreach (win[i]) s += win[i];
                        m_avg    = s / DEPTH;
                        m_locked = 1'b1;
                        vq.push_back('{cyc, m_avg});
                    end
                    pend = 1'b0;
                    case (m_state)
                        IDLE: m_state = ARM;
                        ARM: if (e) begin
                            m_state = MEASURE;
                            t0      = cyc;
                        end
                        default: begin
                            d = cyc - t0;
                            if (d >= MAXT * TD) begin
                                m_lost   = 1'b1;
                                m_locked = 1'b0;
                                win.delete();
                                m_state  = ARM;
                            end else if (e) begin
                                ticks = (d - 1) / TD;
                                if (ticks < MINT) begin
                                    aq.push_back(cyc);
                                end else begin
                                    win.push_front(ticks);
                                    if (win.size() > DEPTH) void'(win.pop_back());
                                    m_lost = 1'b0;
                                    t0     = cyc;
                                    pend   = 1'b1;
                                end
                            end
                        end
                    endcase
                end
            end
        end
    end

    task automatic rec(input bit ok, input string name, input int act, input int exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
    endtask

    // Monitor: strobes are matched against the scoreboard queues, levels against the model.
    initial begin
        bit v_here;
        bit a_here;
        forever begin
            @(negedge clk);
            while (vr < vq.size() && vq[vr].cyc < cyc) vr++;
            while (ar < aq.size() && aq[ar] < cyc) ar++;
            v_here = !reset && vr < vq.size() && vq[vr].cyc == cyc;
            a_here = !reset && ar < aq.size() && aq[ar] == cyc;
            rec(avg_valid == v_here, "avg_valid", int'(avg_valid), int'(v_here));
            if (v_here) begin
                if (avg_valid)
                    rec(int'(avg_interval) == vq[vr].val, "avg_on_valid",
                        int'(avg_interval), vq[vr].val);
                vr++;
            end
            rec(artefact == a_here, "artefact", int'(artefact), int'(a_here));
            if (a_here) ar++;
            rec(locked == m_locked, "locked", int'(locked), int'(m_locked));
            rec(signal_lost == m_lost, "signal_lost", int'(signal_lost), int'(m_lost));
            rec(int'(avg_interval) == m_avg, "avg_interval", int'(avg_interval), m_avg);
            rec(dut.state == m_state, "state", int'(dut.state), int'(m_state));
        end
    end

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic beat(input int gap);
        pulse_in = 1'b1;
        edge_due[cyc + 3] = 1'b1;
        tick_n(4);
        pulse_in = 1'b0;
        tick_n(gap - 4);
    endtask

    initial begin
        int gaps [17];
        int r;
        int gap;
        // 42 clk = 10 ticks, 33 = 8, 49 = 12, 65 = 16; 8 is an artefact, 100 a loss
        gaps = '{42, 42, 42, 42, 33, 33, 49, 49, 65, 8, 34, 100, 42, 42, 42, 42, 30};
        tick_n(3);
        reset  = 1'b0;
        enable = 1'b1;
        tick_n(3);
        foreach (gaps[i]) beat(gaps[i]);

        enable = 1'b0;
        repeat (3) beat(20);
        enable = 1'b1;
        tick_n(5);

        // Lock, then hit reset while the interval counter sits near 7.
        repeat (4) beat(42);
        pulse_in = 1'b1;
        edge_due[cyc + 3] = 1'b1;
        tick_n(4);
        pulse_in = 1'b0;
        tick_n(28);
        @(posedge clk);
        #2 reset = 1'b1;
        tick_n(3);
        reset = 1'b0;
        tick_n(2);
        beat(42);
        tick_n(10);

        for (int k = 0; k < 80; k++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                enable = 1'b0;
                tick_n(int'($urandom_range(2, 8)));
                enable = 1'b1;
            end
            r = int'($urandom_range(0, 9));
            if (r < 2)       gap = int'($urandom_range(6, 12));
            else if (r == 2) gap = int'($urandom_range(76, 95));
            else             gap = int'($urandom_range(13, 75));
            beat(gap);
        end
        tick_n(10);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
